// File: rtl/imu_yaw_seq_pkg.sv
// Shared types and command words for the IMU yaw-rate sequencer.
// Commands are {rd, addr[6:0], data[7:0]}; reads carry a zero data byte.
package imu_pkg;

    typedef enum logic [2:0] {
        PWR,
        WR1,
        WR2,
        WR3,
        IDLE,
        RDL,
        RDH
    } imu_state_t;

    localparam logic [15:0] CMD_INT_EN   = 16'h0D02;
    localparam logic [15:0] CMD_GYRO_CFG = 16'h1160;
    localparam logic [15:0] CMD_CTRL3    = 16'h1240;
    localparam logic [15:0] CMD_RD_YAWL  = 16'hA600;
    localparam logic [15:0] CMD_RD_YAWH  = 16'hA700;

    function automatic logic is_cmd_state(input imu_state_t s);
        return (s == WR1) || (s == WR2) || (s == WR3) || (s == RDL) || (s == RDH);
    endfunction

    function automatic logic [15:0] state_cmd(input imu_state_t s);
        logic [15:0] c;
        c = 16'h0000;
        case (s)
            WR1:     c = CMD_INT_EN;
            WR2:     c = CMD_GYRO_CFG;
            WR3:     c = CMD_CTRL3;
            RDL:     c = CMD_RD_YAWL;
            RDH:     c = CMD_RD_YAWH;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imu_yaw_seq_if.sv
// Command/response link between the yaw sequencer and the SPI monarch.
interface imu_yaw_seq_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;

    modport master (output snd, output cmd, input done, input resp);
    modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/imu_yaw_seq_int_sync.sv
// Two-flop synchronizer plus a third flop for rising-edge detection.
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/imu_yaw_seq.sv
// IMU yaw sequencer: power-up delay, three config writes, then a low/high
// byte read pair per data-ready interrupt, presenting the yaw rate with a strobe.
//
// state | meaning
// PWR   | power-up delay count
// WR1   | write INT1 data-ready enable
// WR2   | write gyro ODR/range
// WR3   | write block-data-update
// IDLE  | wait for pending interrupt
// RDL   | read yaw-rate low byte
// RDH   | read yaw-rate high byte, publish result
module imu_yaw_seq
    import imu_pkg::*;
#(
    parameter logic [15:0] PWR_DLY = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 INT,
    imu_yaw_seq_if.master        spi,
    output logic [15:0]          yaw_rt,
    output logic                 vld
);
    imu_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        done_q;
    logic [7:0]  low_q, low_d;
    logic [15:0] yaw_q, yaw_d;
    logic        vld_q, vld_d;
    logic        snd_q, snd_d;
    logic [15:0] cmd_q, cmd_d;
    logic        int_rise;
    logic        done_rise;
    logic        resp_hi_unused;

    int_sync u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (INT),
        .rise_o  (int_rise)
    );

    // A done level left over from the previous transaction never counts.
    assign done_rise      = spi.done & ~done_q;
    assign resp_hi_unused = ^spi.resp[15:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PWR;
            cnt_q   <= 16'h0000;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            low_q   <= 8'h00;
            yaw_q   <= 16'h0000;
            vld_q   <= 1'b0;
            snd_q   <= 1'b0;
            cmd_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= spi.done;
            low_q   <= low_d;
            yaw_q   <= yaw_d;
            vld_q   <= vld_d;
            snd_q   <= snd_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        low_d   = low_q;
        yaw_d   = yaw_q;
        vld_d   = 1'b0;
        snd_d   = 1'b0;
        cmd_d   = cmd_q;
        pend_d  = pend_q;

        case (state_q)
            PWR: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == PWR_DLY - 16'd1) state_d = WR1;
            end
            WR1:  if (done_rise) state_d = WR2;
            WR2:  if (done_rise) state_d = WR3;
            WR3:  if (done_rise) state_d = IDLE;
            IDLE: if (pend_q) state_d = RDL;
            RDL: begin
                if (done_rise) begin
                    low_d   = spi.resp[7:0];
                    state_d = RDH;
                end
            end
            RDH: begin
                if (done_rise) begin
                    yaw_d   = {spi.resp[7:0], low_q};
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = PWR;
        endcase

        if ((state_d != state_q) && is_cmd_state(state_d)) begin
            snd_d = 1'b1;
            cmd_d = state_cmd(state_d);
        end

        // A new edge landing on the RDL entry edge must survive the clear.
        pend_d = int_rise | (pend_q & ~((state_q == IDLE) && (state_d == RDL)));
    end

    assign spi.snd = snd_q;
    assign spi.cmd = cmd_q;
    assign yaw_rt  = yaw_q;
    assign vld     = vld_q;
endmodule

// File: tb/tb_imu_yaw_seq.sv
// Directed/randomized bench for imu_yaw_seq with a behavioural SPI responder.
module tb_imu_yaw_seq;
    localparam logic [15:0] DLY = 16'd16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_pin = 1'b0;
    logic [15:0] yaw_rt;
    logic        vld;
    int          checks = 0;
    int          failures = 0;

    imu_yaw_seq_if bus ();

    imu_yaw_seq #(.PWR_DLY(DLY)) dut (
        .clk    (clk),
        .rst    (rst),
        .INT    (int_pin),
        .spi    (bus.master),
        .yaw_rt (yaw_rt),
        .vld    (vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Yaw rate = high byte * 256 + low byte, taken modulo 2^16.
    function automatic logic [15:0] yaw_ref(input logic [15:0] rl, input logic [15:0] rh);
        int v;
        v = (int'(rh) % 256) * 256 + (int'(rl) % 256);
        return 16'(v);
    endfunction

    task automatic wait_snd(input int max, output int n, output bit seen, output bit vseen);
        n = 0;
        seen = 1'b0;
        vseen = 1'b0;
        while (!seen && n < max) begin
            tick();
            n++;
            if (vld === 1'b1) vseen = 1'b1;
            if (bus.snd === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic expect_cmd(input string tag, input logic [15:0] exp_cmd,
                              input int exp_n, input bit start);
        int n;
        bit seen, vs;
        wait_snd(exp_n + 20, n, seen, vs);
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_lat"}, 32'(n), 32'(exp_n));
            chk({tag, "_cmd"}, 32'(bus.cmd), 32'(exp_cmd));
        end
        if (start) bus.done = 1'b0;
    endtask

    task automatic complete(input logic [15:0] r, input int lat);
        tick();
        chk("snd_pulse", 32'(bus.snd), 32'd0);
        repeat (lat - 1) tick();
        bus.resp = r;
        bus.done = 1'b1;
    endtask

    task automatic do_pair(input string tag, input logic [15:0] rl, input logic [15:0] rh,
                           input int la, input int lb, input bit more);
        complete(rl, la);
        expect_cmd({tag, "_rdh"}, 16'hA700, 1, 1'b1);
        complete(rh, lb);
        tick();
        chk({tag, "_vld"}, 32'(vld), 32'd1);
        chk({tag, "_yaw"}, 32'(yaw_rt), 32'(yaw_ref(rl, rh)));
        if (!more) begin
            tick();
            chk({tag, "_vld_once"}, 32'(vld), 32'd0);
            chk({tag, "_no_snd"}, 32'(bus.snd), 32'd0);
        end
    endtask

    task automatic quiet(input string tag, input int cyc);
        int n;
        bit seen, vs;
        wait_snd(cyc, n, seen, vs);
        chk({tag, "_no_snd"}, 32'(seen), 32'd0);
        chk({tag, "_no_vld"}, 32'(vs), 32'd0);
    endtask

    initial begin
        logic [15:0] rl, rh;
        int n;
        bit seen, vs;

        bus.done = 1'b0;
        bus.resp = 16'h0000;
        repeat (3) tick();
        chk("rst_snd", 32'(bus.snd), 32'd0);
        chk("rst_cmd", 32'(bus.cmd), 32'd0);
        chk("rst_yaw", 32'(yaw_rt), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);

        // Power-up delay and configuration writes, WR2 with a stale done.
        rst = 1'b0;
        expect_cmd("wr1", 16'h0D02, int'(DLY), 1'b1);
        complete(16'($urandom), 1 + int'($urandom_range(0, 3)));
        expect_cmd("wr2", 16'h1160, 1, 1'b0);
        wait_snd(4, n, seen, vs);
        chk("stale_done_hold", 32'(seen), 32'd0);
        bus.done = 1'b0;
        complete(16'($urandom), 1 + int'($urandom_range(0, 3)));
        expect_cmd("wr3", 16'h1240, 1, 1'b1);
        complete(16'($urandom), 1 + int'($urandom_range(0, 3)));
        quiet("idle", 12);

        // Directed read pair.
        int_pin = 1'b1;
        expect_cmd("dir_rdl", 16'hA600, 4, 1'b1);
        int_pin = 1'b0;
        do_pair("dir", 16'h0034, 16'h00F2, 2, 3, 1'b0);
        chk("dir_yaw_const", 32'(yaw_rt), 32'h0000F234);

        // Randomized read pairs.
        for (int i = 0; i < 6; i++) begin
            rl = 16'($urandom);
            rh = 16'($urandom);
            int_pin = 1'b1;
            expect_cmd("rnd_rdl", 16'hA600, 4, 1'b1);
            int_pin = 1'b0;
            do_pair("rnd", rl, rh, 1 + int'($urandom_range(0, 4)),
                    1 + int'($urandom_range(0, 4)), 1'b0);
        end

        // Three edges during an in-flight pair merge into one more pair.
        int_pin = 1'b1;
        expect_cmd("mrg_rdl", 16'hA600, 4, 1'b1);
        int_pin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            int_pin = 1'b1;
            tick();
            tick();
            int_pin = 1'b0;
        end
        do_pair("mrg1", 16'($urandom), 16'($urandom), 2, 2, 1'b1);
        expect_cmd("mrg2_rdl", 16'hA600, 1, 1'b1);
        do_pair("mrg2", 16'($urandom), 16'($urandom), 2, 2, 1'b0);
        quiet("mrg_end", 20);

        // Fresh edge on the same edge that enters RDL keeps pend set.
        int_pin = 1'b1;
        expect_cmd("coi_rdl", 16'hA600, 4, 1'b1);
        int_pin = 1'b0;
        tick();
        int_pin = 1'b1;
        tick();
        tick();
        int_pin = 1'b0;
        rl = 16'($urandom);
        rh = 16'($urandom);
        complete(rl, 2);
        expect_cmd("coi_rdh", 16'hA700, 1, 1'b1);
        tick();
        tick();
        int_pin = 1'b1;
        tick();
        bus.resp = rh;
        bus.done = 1'b1;
        tick();
        chk("coi_vld", 32'(vld), 32'd1);
        chk("coi_yaw", 32'(yaw_rt), 32'(yaw_ref(rl, rh)));
        expect_cmd("coi2_rdl", 16'hA600, 1, 1'b1);
        int_pin = 1'b0;
        do_pair("coi2", 16'($urandom), 16'($urandom), 3, 1, 1'b1);
        expect_cmd("coi3_rdl", 16'hA600, 1, 1'b1);
        do_pair("coi3", 16'($urandom), 16'($urandom), 1, 3, 1'b0);
        quiet("coi_end", 20);

        // Reset in the middle of the RDH transaction.
        int_pin = 1'b1;
        expect_cmd("rst_rdl", 16'hA600, 4, 1'b1);
        int_pin = 1'b0;
        complete(16'($urandom), 2);
        expect_cmd("rst_rdh", 16'hA700, 1, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_snd", 32'(bus.snd), 32'd0);
        chk("mid_rst_cmd", 32'(bus.cmd), 32'd0);
        chk("mid_rst_yaw", 32'(yaw_rt), 32'd0);
        chk("mid_rst_vld", 32'(vld), 32'd0);
        bus.resp = 16'($urandom);
        bus.done = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wait_snd(int'(DLY) + 20, n, seen, vs);
        chk("rerun_seen", 32'(seen), 32'd1);
        chk("rerun_lat", 32'(n), 32'(DLY));
        chk("rerun_cmd", 32'(bus.cmd), 32'h00000D02);
        chk("rerun_no_vld", 32'(vs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
